// File: rtl/piezo_pkg.sv
// piezo_pkg: shared sizing, types and the per-channel duty comparator for the phase generator.
// Revision 1.0
`default_nettype none
`timescale 1ns/1ps

package piezo_pkg;

   localparam int N_CH    = 89;
   localparam int STEPS   = 125;
   localparam int PHASE_W = 7;
   localparam int ADDR_W  = 7;
   localparam int DUTY    = 62;

   localparam int ST_RUN  = 0;
   localparam int ST_PEND = 1;
   localparam int ST_ERR  = 2;

   typedef logic [PHASE_W-1:0] phase_t;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      PEND = 1'b1
   } commit_state_t;

   // Distance from the channel's phase to the counter, modulo STEPS, one bit wider than a phase.
   function automatic logic in_duty(input phase_t cnt, input phase_t ph);
      logic [PHASE_W:0] c;
      logic [PHASE_W:0] p;
      logic [PHASE_W:0] d;
      c = {1'b0, cnt};
      p = {1'b0, ph};
      d = (c >= p) ? (c - p) : (c + (PHASE_W+1)'(STEPS) - p);
      return (d < (PHASE_W+1)'(DUTY));
   endfunction

endpackage

`default_nettype wire

// File: rtl/piezo_tick_sync.sv
// piezo_tick_sync: brings the divider tick into clk and emits a one-cycle step per rising edge.
// Revision 1.0
`default_nettype none
`timescale 1ns/1ps

module piezo_tick_sync (
   input  logic clk,
   input  logic reset,
   input  logic tick_in,
   output logic step
);

   logic sync_meta;
   logic sync_q;
   logic sync_prev;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_meta <= 1'b0;
         sync_q    <= 1'b0;
         sync_prev <= 1'b0;
         step      <= 1'b0;
      end else begin
         sync_meta <= tick_in;
         sync_q    <= sync_meta;
         sync_prev <= sync_q;
         step      <= sync_q & ~sync_prev;
      end
   end

endmodule

`default_nettype wire

// File: rtl/piezo_phase_generator.sv
// piezo_phase_generator: per-channel phase-shifted square waves with a shadow/active phase bank.
// Revision 1.0
`default_nettype none
`timescale 1ns/1ps

module piezo_phase_generator
   import piezo_pkg::*;
(
   input  logic                clk,
   input  logic                reset,
   input  logic                tick_in,
   input  logic                enable,
   input  logic                wr_en,
   input  logic [ADDR_W-1:0]   wr_addr,
   input  logic [PHASE_W-1:0]  wr_data,
   input  logic                commit,
   input  logic                clr_err,
   output logic [N_CH-1:0]     piezo_out,
   output logic                piezo_en,
   output logic [2:0]          status
);

   // Reset asserts asynchronously everywhere but releases on a clk edge.
   logic rst_meta;
   logic rst_int;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rst_meta <= 1'b1;
         rst_int  <= 1'b1;
      end else begin
         rst_meta <= 1'b0;
         rst_int  <= rst_meta;
      end
   end

   logic          step;
   logic          wrap;
   logic          copy;
   logic          wr_ok;
   logic          err;
   phase_t        cnt;
   commit_state_t state;
   commit_state_t state_nxt;

   piezo_tick_sync u_tick_sync (
      .clk     (clk),
      .reset   (rst_int),
      .tick_in (tick_in),
      .step    (step)
   );

   assign wrap  = step & enable & (cnt == phase_t'(STEPS-1));
   assign copy  = (state == PEND) & wrap;
   assign wr_ok = wr_en && (wr_addr < ADDR_W'(N_CH)) && (wr_data < PHASE_W'(STEPS));

   always_ff @(posedge clk or posedge rst_int) begin
      if (rst_int) begin
         cnt <= '0;
      end else if (!enable) begin
         cnt <= '0;
      end else if (step) begin
         cnt <= wrap ? '0 : cnt + phase_t'(1);
      end
   end

   always_ff @(posedge clk or posedge rst_int) begin
      if (rst_int) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // A commit landing on a wrap only arms the copy; it fires at the following wrap.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (commit) state_nxt = PEND;
         PEND:    if (wrap)   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst_int) begin
      if (rst_int) begin
         err      <= 1'b0;
         piezo_en <= 1'b0;
      end else begin
         piezo_en <= enable;
         if (wr_en && !wr_ok) begin
            err <= 1'b1;
         end else if (clr_err) begin
            err <= 1'b0;
         end
      end
   end

   always_comb begin
      status          = '0;
      status[ST_RUN]  = piezo_en;
      status[ST_PEND] = (state == PEND);
      status[ST_ERR]  = err;
   end

   generate
      for (genvar i = 0; i < N_CH; i++) begin : g_ch
         phase_t shadow;
         phase_t active;
         logic   drive;

         always_ff @(posedge clk or posedge rst_int) begin
            if (rst_int) begin
               shadow <= '0;
               active <= '0;
               drive  <= 1'b0;
            end else begin
               if (wr_ok && (wr_addr == ADDR_W'(i))) begin
                  shadow <= wr_data;
               end
               // Non-blocking copy takes the shadow value from before any same-cycle write.
               if (copy) begin
                  active <= shadow;
               end
               drive <= enable & in_duty(cnt, active);
            end
         end

         assign piezo_out[i] = drive;
      end
   endgenerate

endmodule

`default_nettype wire

// File: tb/tb_piezo_phase_generator.sv
// tb_piezo_phase_generator: directed vectors for the phase generator with hand-computed expectations.
// Revision 1.0
`default_nettype none
`timescale 1ns/1ps

module tb_piezo_phase_generator;
   import piezo_pkg::*;

   logic               clk = 1'b0;
   logic               reset;
   logic               tick_in;
   logic               enable;
   logic               wr_en;
   logic [ADDR_W-1:0]  wr_addr;
   logic [PHASE_W-1:0] wr_data;
   logic               commit;
   logic               clr_err;
   logic [N_CH-1:0]    piezo_out;
   logic               piezo_en;
   logic [2:0]         status;

   int checks  = 0;
   int errors  = 0;
   int cur_cnt = 0;

   localparam logic [N_CH-1:0] ALL  = '1;
   localparam logic [N_CH-1:0] NONE = '0;

   typedef struct {
      string           nm;
      int              cnt;
      logic [N_CH-1:0] exp;
   } vec_t;

   vec_t tbl [6];

   piezo_phase_generator dut (
      .clk       (clk),
      .reset     (reset),
      .tick_in   (tick_in),
      .enable    (enable),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .commit    (commit),
      .clr_err   (clr_err),
      .piezo_out (piezo_out),
      .piezo_en  (piezo_en),
      .status    (status)
   );

   always #10 clk = ~clk;

   function automatic logic [N_CH-1:0] bit_of(input int i);
      logic [N_CH-1:0] v;
      v    = '0;
      v[i] = 1'b1;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // One divider tick; long enough for the sync, counter and output registers to settle.
   task automatic step();
      tick_in = 1'b1;
      repeat (3) @(negedge clk);
      tick_in = 1'b0;
      repeat (3) @(negedge clk);
      if (enable) cur_cnt = (cur_cnt + 1) % STEPS;
   endtask

   task automatic goto(input int tgt);
      for (int k = 0; k < STEPS && cur_cnt != tgt; k++) step();
   endtask

   task automatic at(input int tgt, input logic [N_CH-1:0] exp, input string nm);
      goto(tgt);
      chk(nm, piezo_out, exp);
   endtask

   task automatic wr(input int addr, input int data, input logic clr);
      wr_en   = 1'b1;
      wr_addr = ADDR_W'(addr);
      wr_data = PHASE_W'(data);
      clr_err = clr;
      @(negedge clk);
      wr_en   = 1'b0;
      clr_err = 1'b0;
   endtask

   task automatic pulse_commit();
      commit = 1'b1;
      @(negedge clk);
      commit = 1'b0;
   endtask

   task automatic pulse_clr();
      clr_err = 1'b1;
      @(negedge clk);
      clr_err = 1'b0;
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      reset   = 1'b1;
      tick_in = 1'b0;
      enable  = 1'b1;
      wr_en   = 1'b0;
      wr_addr = '0;
      wr_data = '0;
      commit  = 1'b0;
      clr_err = 1'b0;

      tbl[0] = '{"c1_cnt0",   0,   ALL};
      tbl[1] = '{"c1_cnt1",   1,   ALL};
      tbl[2] = '{"c1_cnt61",  61,  ALL};
      tbl[3] = '{"c1_cnt62",  62,  NONE};
      tbl[4] = '{"c1_cnt124", 124, NONE};
      tbl[5] = '{"c1_wrap0",  0,   ALL};

      // Case 1: reset with the tick running, then all phases zero.
      @(negedge clk);
      step();
      step();
      chk("rst_out", piezo_out, NONE);
      chk("rst_en", piezo_en, 1'b0);
      chk("rst_status", status, 3'b000);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      cur_cnt = 0;
      chk("c1_en", piezo_en, 1'b1);
      chk("c1_status", status, 3'b001);
      for (int v = 0; v < 6; v++) at(tbl[v].cnt, tbl[v].exp, tbl[v].nm);

      // Case 2: ch5 = 62 becomes the inverse of ch0 after the wrap.
      wr(5, 62, 1'b0);
      pulse_commit();
      chk("c2_pend", status, 3'b011);
      chk("c2_cnt0_old", piezo_out, ALL);
      at(62, NONE, "c2_cnt62_old");
      at(124, NONE, "c2_cnt124_old");
      chk("c2_pend_pre_wrap", status, 3'b011);
      at(0, ALL & ~bit_of(5), "c2_cnt0_new");
      chk("c2_pend_clear", status, 3'b001);
      at(61, ALL & ~bit_of(5), "c2_cnt61");
      at(62, bit_of(5), "c2_cnt62");
      at(123, bit_of(5), "c2_cnt123");
      at(124, NONE, "c2_cnt124");

      // Case 3: a later write before the wrap wins.
      at(30, ALL & ~bit_of(5), "c3_cnt30");
      wr(88, 10, 1'b0);
      pulse_commit();
      chk("c3_pend", status, 3'b011);
      goto(50);
      wr(88, 20, 1'b0);
      at(100, bit_of(5), "c3_cnt100_old");
      chk("c3_pend_100", status, 3'b011);
      goto(124);
      chk("c3_pend_124", status, 3'b011);
      at(0, ALL & ~bit_of(5) & ~bit_of(88), "c3_cnt0_new");
      chk("c3_pend_clear", status, 3'b001);
      at(19, ALL & ~bit_of(5) & ~bit_of(88), "c3_cnt19");
      at(20, ALL & ~bit_of(5), "c3_cnt20");
      at(81, bit_of(5) | bit_of(88), "c3_cnt81");
      at(82, bit_of(5), "c3_cnt82");

      // Case 4: rejected writes set a sticky error; set wins over clear.
      wr(89, 5, 1'b0);
      chk("c4_bad_addr", status, 3'b101);
      pulse_clr();
      chk("c4_clr", status, 3'b001);
      wr(0, 127, 1'b1);
      chk("c4_set_wins", status, 3'b101);
      wr(0, 125, 1'b0);
      chk("c4_bad_data", status, 3'b101);
      pulse_clr();
      chk("c4_clr2", status, 3'b001);
      pulse_commit();
      goto(124);
      at(0, ALL & ~bit_of(5) & ~bit_of(88), "c4_shadow_kept");

      // Case 5: drop enable at cnt 40, then restart.
      at(40, ALL & ~bit_of(5), "c5_cnt40");
      enable = 1'b0;
      @(negedge clk);
      chk("c5_off_out", piezo_out, NONE);
      chk("c5_off_en", piezo_en, 1'b0);
      chk("c5_off_status", status, 3'b000);
      wr(5, 0, 1'b0);
      pulse_commit();
      chk("c5_off_pend", status, 3'b010);
      step();
      chk("c5_off_step", piezo_out, NONE);
      cur_cnt = 0;
      enable  = 1'b1;
      @(negedge clk);
      chk("c5_on_cnt0", piezo_out, ALL & ~bit_of(5) & ~bit_of(88));
      chk("c5_on_status", status, 3'b011);
      step();
      chk("c5_on_cnt1", piezo_out, ALL & ~bit_of(5) & ~bit_of(88));
      at(61, ALL & ~bit_of(5), "c5_cnt61");
      at(62, bit_of(5) | bit_of(88), "c5_cnt62");

      // Case 6: asynchronous reset mid-period with a commit pending.
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      chk("c6_async_out", piezo_out, NONE);
      chk("c6_async_en", piezo_en, 1'b0);
      chk("c6_async_status", status, 3'b000);
      @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      cur_cnt = 0;
      chk("c6_active_clear", piezo_out, ALL);
      chk("c6_status", status, 3'b001);
      pulse_commit();
      goto(124);
      at(0, ALL, "c6_shadow_clear");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
